// File: rtl/reg_writeback_queue.sv
// In-order register-file write queue: MEM/ALU producers enqueue, one write drains per cycle.
// Define REG_WB_BYPASS_EN to forward queued data onto RD1/RD2.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ALU_VALID,
  input  logic [AW-1:0]            ALU_RD,
  input  logic [DW-1:0]            ALU_DATA,
  output logic                     ALU_READY,
  input  logic                     MEM_VALID,
  input  logic [AW-1:0]            MEM_RD,
  input  logic [DW-1:0]            MEM_DATA,
  output logic                     MEM_READY,
  input  logic                     DRAIN_EN,
  output logic [AW-1:0]            A3,
  output logic [DW-1:0]            WD,
  output logic                     WE,
  input  logic [AW-1:0]            A1,
  input  logic [AW-1:0]            A2,
  input  logic [DW-1:0]            RD1_RF,
  input  logic [DW-1:0]            RD2_RF,
  output logic [DW-1:0]            RD1,
  output logic [DW-1:0]            RD2,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a producer transfers when VALID && READY at a rising edge and
  // holds rd/data stable while VALID && !READY. READY depends only on the
  // registered count (plus MEM_VALID for the ALU, since MEM wins arbitration).

  logic [AW-1:0] rd_mem_q   [DEPTH];
  logic [AW-1:0] rd_mem_d   [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [DW-1:0] data_mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          mem_fire, alu_fire, push, pop;
  logic [AW-1:0] enq_rd;
  logic [DW-1:0] enq_data;

  assign FULL      = (count_q == CW'(DEPTH));
  assign EMPTY     = (count_q == '0);
  assign COUNT     = count_q;
  assign MEM_READY = !FULL;
  assign ALU_READY = !FULL && !MEM_VALID;

  assign A3 = EMPTY ? '0 : rd_mem_q[rd_ptr_q];
  assign WD = EMPTY ? '0 : data_mem_q[rd_ptr_q];
  assign WE = pop;

  always_comb begin
    mem_fire   = MEM_VALID && MEM_READY;
    alu_fire   = ALU_VALID && ALU_READY;
    enq_rd     = mem_fire ? MEM_RD : ALU_RD;
    enq_data   = mem_fire ? MEM_DATA : ALU_DATA;
    // Writes to x0 complete the handshake but never occupy an entry.
    push       = (mem_fire || alu_fire) && (enq_rd != '0);
    pop        = !EMPTY && DRAIN_EN;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = enq_rd;
      data_mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

`ifdef REG_WB_BYPASS_EN
  // Walk oldest to youngest so the youngest matching entry wins; the head
  // being written this cycle is still in the window, the incoming request is not.
  always_comb begin
    logic [PW-1:0] idx;
    RD1 = RD1_RF;
    RD2 = RD2_RF;
    idx = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (A1 != '0 && rd_mem_q[idx] == A1) RD1 = data_mem_q[idx];
        if (A2 != '0 && rd_mem_q[idx] == A2) RD2 = data_mem_q[idx];
      end
    end
  end
`else
  logic unused_read_addr;
  assign unused_read_addr = ^{A1, A2};
  assign RD1 = RD1_RF;
  assign RD2 = RD2_RF;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed table-driven bench for reg_writeback_queue plus a scoreboarded wrap sequence.
module tb_reg_writeback_queue;

`ifdef REG_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, drain_en, we, full, empty;
  logic [4:0]  alu_rd, mem_rd, a3, a1, a2;
  logic [31:0] alu_data, mem_data, wd, rd1_rf, rd2_rf, rd1, rd2;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  reg_writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .CLK(clk), .RST(rst),
    .ALU_VALID(alu_valid), .ALU_RD(alu_rd), .ALU_DATA(alu_data), .ALU_READY(alu_ready),
    .MEM_VALID(mem_valid), .MEM_RD(mem_rd), .MEM_DATA(mem_data), .MEM_READY(mem_ready),
    .DRAIN_EN(drain_en), .A3(a3), .WD(wd), .WE(we),
    .A1(a1), .A2(a2), .RD1_RF(rd1_rf), .RD2_RF(rd2_rf), .RD1(rd1), .RD2(rd2),
    .FULL(full), .EMPTY(empty), .COUNT(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        drain;
    logic [4:0]  a1;
    logic [31:0] rf1;
    logic        chk, we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [2:0]  cnt;
    logic        ardy, mrdy, hit;
    logic [31:0] byp;
  } vec_t;

  vec_t vq[$];
  logic [36:0] exp_q[$];

  function automatic vec_t mk(
    input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md, input logic dr,
    input logic [4:0] ra, input logic [31:0] rf, input logic chk, input logic e_we,
    input logic [4:0] e_a3, input logic [31:0] e_wd, input logic [2:0] e_cnt,
    input logic e_ardy, input logic e_mrdy, input logic e_hit, input logic [31:0] e_byp);
    vec_t v;
    v.rst = r; v.av = av; v.ard = ard; v.adata = ad; v.mv = mv; v.mrd = mrd;
    v.mdata = md; v.drain = dr; v.a1 = ra; v.rf1 = rf; v.chk = chk; v.we = e_we;
    v.a3 = e_a3; v.wd = e_wd; v.cnt = e_cnt; v.ardy = e_ardy; v.mrdy = e_mrdy;
    v.hit = e_hit; v.byp = e_byp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    rst = v.rst; alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.mdata; drain_en = v.drain;
    a1 = v.a1; a2 = v.a1; rd1_rf = v.rf1; rd2_rf = v.rf1 ^ 32'hFFFF_0000;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0; drain_en = 1'b0;
    a1 = '0; a2 = '0; rd1_rf = '0; rd2_rf = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    // reset then idle
    vq.push_back(mk(1,0,0,0,          0,0,0,0, 0,0,     0, 0,0,0,0,1,1,0,0));
    vq.push_back(mk(1,0,0,0,          0,0,0,0, 0,0,     1, 0,0,0,0,1,1,0,0));
    // single write and read-back
    vq.push_back(mk(0,1,5,32'hA5,     0,0,0,1, 5,0,     1, 0,0,0,0,1,1,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 5,0,     1, 1,5,32'hA5,1,1,1,1,32'hA5));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 5,32'hA5,1, 0,0,0,0,1,1,0,0));
    // fill with drain off, then drain in order
    vq.push_back(mk(0,1,1,32'h11,     0,0,0,0, 0,0,     1, 0,0,0,0,1,1,0,0));
    vq.push_back(mk(0,1,2,32'h22,     0,0,0,0, 0,0,     1, 0,1,32'h11,1,1,1,0,0));
    vq.push_back(mk(0,1,3,32'h33,     0,0,0,0, 0,0,     1, 0,1,32'h11,2,1,1,0,0));
    vq.push_back(mk(0,1,4,32'h44,     0,0,0,0, 0,0,     1, 0,1,32'h11,3,1,1,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,0, 0,0,     1, 0,1,32'h11,4,0,0,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,     1, 1,1,32'h11,4,0,0,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,     1, 1,2,32'h22,3,1,1,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,     1, 1,3,32'h33,2,1,1,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,     1, 1,4,32'h44,1,1,1,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,     1, 0,0,0,0,1,1,0,0));
    // contention: MEM wins, ALU waits one cycle
    vq.push_back(mk(0,1,8,32'h1234,   1,7,32'hDEADBEEF,1, 0,0, 1, 0,0,0,0,0,1,0,0));
    vq.push_back(mk(0,1,8,32'h1234,   0,0,0,1, 0,0,     1, 1,7,32'hDEADBEEF,1,1,1,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,     1, 1,8,32'h1234,1,1,1,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,     1, 0,0,0,0,1,1,0,0));
    // x0 filter
    vq.push_back(mk(0,1,0,32'h5555,   0,0,0,1, 0,0,     1, 0,0,0,0,1,1,0,0));
    vq.push_back(mk(0,0,0,0,          1,0,32'h6666,1, 0,0, 1, 0,0,0,0,0,1,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,     1, 0,0,0,0,1,1,0,0));
    // bypass: two pending writes to r3
    vq.push_back(mk(0,1,3,32'h1,      0,0,0,0, 3,0,     1, 0,0,0,0,1,1,0,0));
    vq.push_back(mk(0,1,3,32'h2,      0,0,0,0, 3,0,     1, 0,3,32'h1,1,1,1,1,32'h1));
    vq.push_back(mk(0,0,0,0,          0,0,0,0, 3,0,     1, 0,3,32'h1,2,1,1,1,32'h2));
    vq.push_back(mk(0,0,0,0,          0,0,0,0, 0,32'h77,1, 0,3,32'h1,2,1,1,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 3,0,     1, 1,3,32'h1,2,1,1,1,32'h2));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 3,32'h1, 1, 1,3,32'h2,1,1,1,1,32'h2));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 3,32'h2, 1, 0,0,0,0,1,1,0,0));
    // reset mid-operation discards pending writes
    vq.push_back(mk(0,1,10,32'hAA,    0,0,0,0, 0,0,     1, 0,0,0,0,1,1,0,0));
    vq.push_back(mk(0,1,11,32'hBB,    0,0,0,0, 0,0,     1, 0,10,32'hAA,1,1,1,0,0));
    vq.push_back(mk(1,0,0,0,          0,0,0,1, 0,0,     1, 1,10,32'hAA,2,1,1,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,     1, 0,0,0,0,1,1,0,0));

    for (int i = 0; i < vq.size(); i++) begin
      logic [31:0] e1, e2;
      @(negedge clk);
      drive(vq[i]);
      #1;
      if (vq[i].chk) begin
        e1 = (BYP && vq[i].hit) ? vq[i].byp : vq[i].rf1;
        e2 = (BYP && vq[i].hit) ? vq[i].byp : (vq[i].rf1 ^ 32'hFFFF_0000);
        check($sformatf("v%0d_we", i),    {31'd0, we},        {31'd0, vq[i].we});
        check($sformatf("v%0d_a3", i),    {27'd0, a3},        {27'd0, vq[i].a3});
        check($sformatf("v%0d_wd", i),    wd,                 vq[i].wd);
        check($sformatf("v%0d_count", i), {29'd0, count},     {29'd0, vq[i].cnt});
        check($sformatf("v%0d_full", i),  {31'd0, full},      {31'd0, vq[i].cnt == 3'd4});
        check($sformatf("v%0d_empty", i), {31'd0, empty},     {31'd0, vq[i].cnt == 3'd0});
        check($sformatf("v%0d_alu_rdy", i), {31'd0, alu_ready}, {31'd0, vq[i].ardy});
        check($sformatf("v%0d_mem_rdy", i), {31'd0, mem_ready}, {31'd0, vq[i].mrdy});
        check($sformatf("v%0d_rd1", i),   rd1,                e1);
        check($sformatf("v%0d_rd2", i),   rd2,                e2);
      end
    end

    // wrap: ten back-to-back writes drained against an expected queue
    begin
      int sent = 0;
      int cyc  = 0;
      while ((sent < 10 || exp_q.size() != 0) && cyc < 60) begin
        @(negedge clk);
        idle_inputs();
        drain_en = 1'b1;
        if (sent < 10) begin
          alu_valid = 1'b1;
          alu_rd    = 5'(sent + 1);
          alu_data  = 32'h100 + 32'(sent);
        end
        #1;
        if (we) begin
          if (exp_q.size() == 0) check("wrap_spurious_we", {31'd0, we}, 32'd0);
          else check($sformatf("wrap_beat_%0d", cyc), {a3, wd}, 32'(exp_q.pop_front()));
        end
        if (alu_valid && alu_ready) begin
          exp_q.push_back({alu_rd, alu_data});
          sent++;
        end
        cyc++;
      end
      check("wrap_all_sent", 32'(sent), 32'd10);
      check("wrap_queue_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      check("wrap_end_count", {29'd0, count}, 32'd0);
      check("wrap_end_empty", {31'd0, empty}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-port initiator for the 32x32 register file. It accepts destination-register writes from two producers: the ALU/writeback stage and the data cache load-return path, which completes late on a miss. Accepted writes are buffered in a small in-order queue and drained onto the register file's A3/WD/WE port one per cycle. Optionally, queued data is forwarded onto the read-data path so reads never see a stale register while a write is pending.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- AW, 5, register address width
- DW, 32, register data width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- ALU_VALID  in  1  ALU write request
- ALU_RD  in  AW  ALU destination register
- ALU_DATA  in  DW  ALU result
- ALU_READY  out  1  ALU request accepted this cycle
- MEM_VALID  in  1  cache load-return write request
- MEM_RD  in  AW  load destination register
- MEM_DATA  in  DW  load data
- MEM_READY  out  1  load request accepted this cycle
- DRAIN_EN  in  1  register-file write port available this cycle
- A3  out  AW  register-file write address
- WD  out  DW  register-file write data
- WE  out  1  register-file write enable
- A1, A2  in  AW  register-file read addresses (snooped)
- RD1_RF, RD2_RF  in  DW  raw register-file read data
- RD1, RD2  out  DW  read data delivered to the datapath
- FULL  out  1  count == DEPTH
- EMPTY  out  1  count == 0
- COUNT  out  log2(DEPTH)+1  occupied entries

## Operation
- Storage: DEPTH entries of {rd, data}. Write pointer and read pointer are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Arbitration: at most one enqueue per cycle. MEM has priority over ALU.
  - MEM_READY = !FULL.
  - ALU_READY = !FULL && !MEM_VALID.
- Handshake: a transfer occurs when VALID && READY at a rising edge. The producer holds rd/data stable while VALID && !READY.
- x0 filter: an accepted request with rd == 0 completes the handshake but is not enqueued, and COUNT does not change.
- Drain: when !EMPTY, the head drives A3 = head.rd, WD = head.data, and WE = DRAIN_EN. The head is popped at the edge where WE = 1.
- Simultaneous enqueue and pop: COUNT is unchanged and both pointers advance. FULL blocks enqueue even if a pop occurs in the same cycle; readiness depends only on registered COUNT.
- Ordering: drain order equals acceptance order. Multiple pending writes to the same rd are all written, oldest first.
- Read path: RD1/RD2 come either from the bypass (see Configuration) or directly from RD1_RF/RD2_RF.

## Timing
- Reset (RST high at an edge): pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0. Queue contents are don't-care.
- Outputs while EMPTY, including immediately after reset: WE = 0, A3 = 0, WD = 0.
- Latency: a request accepted at edge N is at the head after edge N if the queue was empty. WE asserts in cycle N+1 and the register file captures it at edge N+1, giving one-cycle accept-to-write latency when DRAIN_EN = 1.
- READY, FULL, EMPTY, COUNT: combinational from registered state only. No combinational path from VALID to READY except ALU_READY depending on MEM_VALID.
- RST asserted mid-operation discards all pending writes. WE is 0 in the cycle after the reset edge.
- DRAIN_EN low: the head is held, and A3/WD stay driven with WE = 0.

## Configuration
- Macro: REG_WB_BYPASS_EN.
- Defined:
  - RD1 = data of the youngest valid queue entry whose rd == A1, else RD1_RF. RD2 is computed the same way from A2.
  - The search includes the head being written in the current cycle. It excludes the request being accepted in the current cycle.
  - A1/A2 == 0 always returns RD*_RF.
  - The path is purely combinational.
- Undefined: RD1 = RD1_RF and RD2 = RD2_RF; no comparators are built.

## Test plan
- Reset then idle: RST 1 for 2 cycles -> WE = 0, A3 = 0, WD = 0, EMPTY = 1, COUNT = 0, ALU_READY = MEM_READY = 1.
- Single write: ALU_VALID with rd = 5, data = 0x0000_00A5, DRAIN_EN = 1 -> next cycle WE = 1, A3 = 5, WD = 0xA5; reading A1 = 5 two cycles later returns 0xA5.
- Fill and block: DRAIN_EN = 0, enqueue rd = 1..4 with data 0x11..0x44 -> FULL = 1, COUNT = 4, MEM_READY = 0. Raise DRAIN_EN -> writes 1,2,3,4 in order on consecutive cycles, and EMPTY after the 4th.
- Contention: MEM_VALID (rd = 7, 0xDEAD_BEEF) and ALU_VALID (rd = 8, 0x1234) in the same cycle -> MEM accepted first, ALU_READY = 0 that cycle. ALU accepted the next cycle, drain order 7 then 8.
- x0 and wrap: enqueue rd = 0 -> handshake completes, COUNT stays 0, no WE. Then push/pop 10 entries -> pointers wrap and all 10 are written in order.
- Bypass (REG_WB_BYPASS_EN): DRAIN_EN = 0, queue rd = 3 data 0x1 then rd = 3 data 0x2. With A1 = 3 and RD1_RF = 0, RD1 = 0x2. Without the macro, RD1 = 0.
